// File: rtl/mem_buffer_pkg.sv
// Shared width helpers, parameter legality check and the per-edge operation
// encoding used by the mem_buffer_queue block.
package mem_buffer_pkg;

   // Pointer width indexes DEPTH entries; count needs one more bit to hold DEPTH itself.
   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic bit params_ok(input int depth, input int almost_full);
      return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
             (almost_full >= 1) && (almost_full <= depth);
   endfunction

   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } q_op_e;

endpackage

// File: rtl/mem_buffer_queue_if.sv
// Consumer-facing bundle of the memory buffer queue: push/pop requests,
// flush, the registered read port and the occupancy/error status.
interface mem_buffer_queue_if
   import mem_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
);
   logic                      flush;
   logic                      wr_en;
   logic [DATA_WIDTH-1:0]     data_in;
   logic                      rd_en;
   logic [DATA_WIDTH-1:0]     data_out;
   logic                      rd_valid;
   logic [cnt_w(DEPTH)-1:0]   count;
   logic                      full;
   logic                      empty;
   logic                      almost_full;
   logic                      overflow;
   logic                      underflow;

   modport master (
      output flush, wr_en, data_in, rd_en,
      input  data_out, rd_valid, count, full, empty, almost_full, overflow, underflow
   );

   modport slave (
      input  flush, wr_en, data_in, rd_en,
      output data_out, rd_valid, count, full, empty, almost_full, overflow, underflow
   );
endinterface

// File: rtl/mem_buffer_ram.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous
// read port, contents never reset.
module mem_buffer_ram
   import mem_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                      clk,
   input  logic                      we_i,
   input  logic [ptr_w(DEPTH)-1:0]   waddr_i,
   input  logic [DATA_WIDTH-1:0]     wdata_i,
   input  logic [ptr_w(DEPTH)-1:0]   raddr_i,
   output logic [DATA_WIDTH-1:0]     rdata_o
);
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // NOTE: storage has no reset so it maps onto RAM/LUTRAM; the occupancy
   // count in the top guarantees stale words are never observed.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/mem_buffer_queue.sv
// In-order DEPTH-entry buffer between the memory stage and its consumer, with
// occupancy flags, flush, sticky push/pop error flags and a registered read port.
module mem_buffer_queue
   import mem_buffer_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 4,
   parameter int ALMOST_FULL = DEPTH - 1
) (
   input  logic               clk,
   input  logic               sync_rst,
   input  logic               clk_en,
   mem_buffer_queue_if.slave  bus
);
   localparam int PTR_W = ptr_w(DEPTH);
   localparam int CNT_W = cnt_w(DEPTH);

   if (!params_ok(DEPTH, ALMOST_FULL)) begin : g_bad_params
      $error("mem_buffer_queue: DEPTH must be a power of two >= 2 and 1 <= ALMOST_FULL <= DEPTH");
   end

   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;

   logic                  full, empty;
   logic                  push_ok, pop_ok;
   logic [DATA_WIDTH-1:0] ram_rdata;
   q_op_e                 op;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

   // Flush swallows both requests; a full queue still accepts a push when a pop frees a slot.
   assign pop_ok  = !bus.flush && bus.rd_en && !empty;
   assign push_ok = !bus.flush && bus.wr_en && (!full || pop_ok);
   assign op      = q_op_e'({push_ok, pop_ok});

   mem_buffer_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_ram (
      .clk     (clk),
      .we_i    (clk_en && push_ok),
      .waddr_i (wr_ptr_q),
      .wdata_i (bus.data_in),
      .raddr_i (rd_ptr_q),
      .rdata_o (ram_rdata)
   );

   // NOTE: every signal written here gets a default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      data_out_d  = data_out_q;
      rd_valid_d  = pop_ok;
      overflow_d  = overflow_q | (!bus.flush && bus.wr_en && !push_ok);
      underflow_d = underflow_q | (!bus.flush && bus.rd_en && !pop_ok);

      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
         rd_ptr_d   = rd_ptr_q + PTR_W'(1);
         data_out_d = ram_rdata;
      end

      unique case (op)
         OP_PUSH: count_d = count_q + CNT_W'(1);
         OP_POP:  count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (sync_rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         data_out_q  <= '0;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (clk_en) begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         data_out_q  <= data_out_d;
         rd_valid_q  <= rd_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign bus.data_out    = data_out_q;
   assign bus.rd_valid    = rd_valid_q;
   assign bus.count       = count_q;
   assign bus.full        = full;
   assign bus.empty       = empty;
   assign bus.almost_full = (count_q >= CNT_W'(ALMOST_FULL));
   assign bus.overflow    = overflow_q;
   assign bus.underflow   = underflow_q;
endmodule

// File: doc/mem_buffer_queue.md
# mem_buffer_queue

Parametrised successor to the single-word memory buffer register: a DEPTH-entry in-order queue of DATA_WIDTH words between the memory stage and its consumer. Adds occupancy tracking, full/empty/almost-full flags, flush, sticky overflow/underflow errors, and a registered read port whose output holds its value between pops. It sits on the memory-side data path and absorbs load-return bursts while the consumer stalls.

## Interface
- DATA_WIDTH, 32, word width in bits
- DEPTH, 4, number of entries; power of two, at least 2
- ALMOST_FULL, DEPTH-1, count at or above which almost_full asserts; range 1..DEPTH
- clk  in  1  rising-edge clock
- sync_rst  in  1  synchronous reset, active-high; acts regardless of clk_en
- clk_en  in  1  global enable; when low, no register changes (except on reset)
- flush  in  1  discard all queued entries
- wr_en  in  1  push request
- data_in  in  DATA_WIDTH  push data
- rd_en  in  1  pop request
- data_out  out  DATA_WIDTH  last popped word, registered
- rd_valid  out  1  data_out was loaded on the previous edge
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= ALMOST_FULL
- overflow  out  1  sticky: a push was dropped
- underflow  out  1  sticky: a pop was dropped

## Operation
- Reset values: data_out 0, rd_valid 0, count 0, empty 1, full 0, almost_full 0 (or 1 only if ALMOST_FULL would be 0, which is illegal), overflow 0, underflow 0, both pointers 0. Storage contents are not reset.
- Per edge with clk_en=1, priority is: flush first, then push/pop.
- flush=1: pointers and count go to 0, rd_valid goes to 0, and wr_en/rd_en that cycle are ignored. data_out, overflow and underflow hold.
- Push accepted when wr_en && (!full || pop accepted same cycle). On acceptance, data_in is written at wr_ptr and wr_ptr increments modulo DEPTH.
- Pop accepted when rd_en && !empty. On acceptance, data_out <= entry at rd_ptr, rd_ptr increments modulo DEPTH, and rd_valid <= 1. Otherwise rd_valid <= 0 and data_out holds.
- Empty with push and pop in the same cycle: the pop is dropped and underflow sets. There is no bypass; the word is enqueued.
- Full with push and pop in the same cycle: both are accepted and count is unchanged.
- Dropped push (wr_en && full && no pop): overflow sets. Dropped pop (rd_en && empty): underflow sets. Both flags clear only on sync_rst.
- count update: +1 push only, -1 pop only, unchanged for both or neither.
- full, empty and almost_full are decoded combinationally from the registered count.
- clk_en=0: all state frozen, including rd_valid and the sticky flags.

## Timing
- Write-to-read latency: a word pushed at edge N is poppable at edge N+1 and appears on data_out after edge N+1.
- Read latency is one edge: rd_en sampled at edge N gives data_out/rd_valid valid after edge N.
- Flags reflect the post-edge count in the same cycle. No combinational path exists from wr_en/rd_en to any output.
- Reset asserted mid-burst: state is cleared at that edge and in-flight words are lost.
- Pointers wrap from DEPTH-1 to 0 with no gap; count distinguishes full from empty.

## Structure
- Package mem_buffer_pkg holds the pointer and count width helper functions (ptr_w = $clog2(DEPTH), cnt_w = ptr_w+1).
- Package mem_buffer_pkg holds the localparam checks: DEPTH a power of two, DEPTH >= 2, 1 <= ALMOST_FULL <= DEPTH.
- One sub-module, mem_buffer_ram: DEPTH x DATA_WIDTH storage with one synchronous write port and one asynchronous read port, no reset.
- The top module holds the pointers, count, flags and output register.

## Test plan
- Fill and drain: DEPTH=4, push 0xA0..0xA3 on consecutive cycles, then pop 4 times.
  - full asserts after the 4th push; almost_full after the 3rd.
  - data_out sequence is A0, A1, A2, A3, each with rd_valid=1.
  - empty is 1 at the end and no error flags are set.
- Overflow: with the queue full, push 0xFF with no pop.
  - count stays 4 and overflow=1.
  - The next 4 pops return the original words; 0xFF never appears.
- Simultaneous at boundaries:
  - Full: push 0xB0 and pop together; count stays 4, the oldest word is popped, and 0xB0 is later popped last.
  - Empty: push 0xC0 and pop together; count becomes 1, underflow=1, rd_valid=0.
- Wrap-around: run 10 interleaved push/pop pairs (push 0x00..0x09).
  - Output order equals input order across pointer wrap, and count never exceeds 1.
- clk_en and flush: load 3 words, drop clk_en for 5 cycles while toggling wr_en/rd_en.
  - count, data_out and rd_valid are unchanged.
  - Then flush with wr_en=1: count becomes 0, data_out holds, and the flush-cycle push is not enqueued.
- Reset mid-operation: with 2 words queued and overflow=1, pulse sync_rst with clk_en=0.
  - All outputs return to their reset values on that edge.
